// File: rtl/roce_write_segmenter.sv
// Splits one RDMA WRITE into PMTU-sized RC packets, one header descriptor each; owns the QP's running PSN.
// Latency: descriptor valid the cycle after start; backpressure holds the registered descriptor while valid && !ready.
// Optional ROCE_SEG_STATS_EN adds saturating counters for accepted descriptors and starts dropped while busy.
module roce_write_segmenter #(
  parameter int PMTU     = 4096,
  parameter int LOG_PMTU = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_transfer,
  input  logic [31:0] dma_length,
  input  logic [31:0] r_key,
  input  logic [23:0] rem_qpn,
  input  logic [23:0] loc_psn,
  input  logic [31:0] rem_ip_addr,
  input  logic [63:0] rem_addr,
  input  logic        write_type,
  input  logic        qp_update,
  output logic        m_desc_valid,
  input  logic        m_desc_ready,
  output logic [7:0]  m_opcode,
  output logic [23:0] m_psn,
  output logic [23:0] m_dest_qp,
  output logic [31:0] m_ip_dest,
  output logic        m_reth_valid,
  output logic [63:0] m_reth_addr,
  output logic [31:0] m_reth_rkey,
  output logic [31:0] m_reth_length,
  output logic        m_immdt_valid,
  output logic [31:0] m_immdt_data,
  output logic [13:0] m_payload_length,
  output logic        m_last,
  output logic [23:0] next_psn,
  output logic        busy,
  output logic        done
`ifdef ROCE_SEG_STATS_EN
  ,
  output logic [31:0] stat_pkts,
  output logic [15:0] stat_starts_dropped
`endif
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  localparam logic [31:0] PMTU_W    = 32'(PMTU);
  localparam logic [31:0] PMTU_MASK = 32'(PMTU - 1);
  localparam logic [13:0] PMTU_LEN  = 14'(PMTU);

  state_t      state, state_nxt;
  logic [31:0] len_q, rkey_q, ip_q, pkt_total, pkt_idx, remaining;
  logic [23:0] qpn_q, psn_reg;
  logic [63:0] addr_q;
  logic        wt_q;
  logic        hs, is_last, start_ok;
  logic [31:0] pkt_calc, pkt_raw;

  assign start_ok = (state == IDLE) && start_transfer;
  assign hs       = m_desc_valid && m_desc_ready;
  assign is_last  = (pkt_idx == pkt_total - 32'd1);
  assign next_psn = psn_reg;

  // ceil(len / PMTU) by shift plus a carry from the sub-PMTU remainder; zero length still makes one packet
  assign pkt_raw  = (dma_length >> LOG_PMTU) + {31'd0, |(dma_length & PMTU_MASK)};
  assign pkt_calc = (pkt_raw == 32'd0) ? 32'd1 : pkt_raw;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    m_desc_valid     = 1'b0;
    m_opcode         = 8'h00;
    m_psn            = 24'd0;
    m_dest_qp        = 24'd0;
    m_ip_dest        = 32'd0;
    m_reth_valid     = 1'b0;
    m_reth_addr      = 64'd0;
    m_reth_rkey      = 32'd0;
    m_reth_length    = 32'd0;
    m_immdt_valid    = 1'b0;
    m_immdt_data     = 32'd0;
    m_payload_length = 14'd0;
    m_last           = 1'b0;
    busy             = (state != IDLE);
    done             = 1'b0;
    case (state)
      IDLE: if (start_transfer) state_nxt = EMIT;
      EMIT: begin
        m_desc_valid = 1'b1;
        if (pkt_total == 32'd1)  m_opcode = wt_q ? 8'h0B : 8'h0A;
        else if (pkt_idx == 32'd0) m_opcode = 8'h06;
        else if (is_last)        m_opcode = wt_q ? 8'h09 : 8'h08;
        else                     m_opcode = 8'h07;
        m_psn            = psn_reg;
        m_dest_qp        = qpn_q;
        m_ip_dest        = ip_q;
        m_reth_valid     = (pkt_idx == 32'd0);
        m_reth_addr      = addr_q;
        m_reth_rkey      = rkey_q;
        m_reth_length    = len_q;
        m_immdt_valid    = is_last && wt_q;
        m_immdt_data     = len_q;
        m_payload_length = is_last ? remaining[13:0] : PMTU_LEN;
        m_last           = is_last;
        if (hs && is_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0; rkey_q <= '0; ip_q <= '0; qpn_q <= '0; addr_q <= '0; wt_q <= 1'b0;
      pkt_total <= '0; pkt_idx <= '0; remaining <= '0; psn_reg <= '0;
    end else begin
      // A PSN load in the start cycle lands before the first descriptor reads psn_reg
      if (state == IDLE && qp_update) psn_reg <= loc_psn;
      else if (hs)                    psn_reg <= psn_reg + 24'd1;
      if (start_ok) begin
        len_q     <= dma_length;
        rkey_q    <= r_key;
        ip_q      <= rem_ip_addr;
        qpn_q     <= rem_qpn;
        addr_q    <= rem_addr;
        wt_q      <= write_type;
        pkt_total <= pkt_calc;
        pkt_idx   <= '0;
        remaining <= dma_length;
      end else if (hs) begin
        pkt_idx   <= pkt_idx + 32'd1;
        remaining <= remaining - PMTU_W;
      end
    end
  end

`ifdef ROCE_SEG_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts           <= '0;
      stat_starts_dropped <= '0;
    end else begin
      if (hs && stat_pkts != '1) stat_pkts <= stat_pkts + 32'd1;
      if (start_transfer && state != IDLE && stat_starts_dropped != '1)
        stat_starts_dropped <= stat_starts_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_roce_write_segmenter.sv
// Directed bench for roce_write_segmenter: packet-list model per transfer, per-cycle descriptor compare, literal pins.
module tb_roce_write_segmenter;
  localparam int PMTU = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start_transfer = 1'b0, write_type = 1'b0, qp_update = 1'b0, m_desc_ready = 1'b0;
  logic [31:0] dma_length = '0, r_key = '0, rem_ip_addr = '0;
  logic [23:0] rem_qpn = '0, loc_psn = '0;
  logic [63:0] rem_addr = '0;
  logic        m_desc_valid, m_reth_valid, m_immdt_valid, m_last, busy, done;
  logic [7:0]  m_opcode;
  logic [23:0] m_psn, m_dest_qp, next_psn;
  logic [31:0] m_ip_dest, m_reth_rkey, m_reth_length, m_immdt_data;
  logic [63:0] m_reth_addr;
  logic [13:0] m_payload_length;
`ifdef ROCE_SEG_STATS_EN
  logic [31:0] stat_pkts;
  logic [15:0] stat_starts_dropped;
`endif

  roce_write_segmenter #(.PMTU(4096), .LOG_PMTU(12)) dut (
    .clk(clk), .rst(rst), .start_transfer(start_transfer), .dma_length(dma_length), .r_key(r_key),
    .rem_qpn(rem_qpn), .loc_psn(loc_psn), .rem_ip_addr(rem_ip_addr), .rem_addr(rem_addr),
    .write_type(write_type), .qp_update(qp_update), .m_desc_valid(m_desc_valid),
    .m_desc_ready(m_desc_ready), .m_opcode(m_opcode), .m_psn(m_psn), .m_dest_qp(m_dest_qp),
    .m_ip_dest(m_ip_dest), .m_reth_valid(m_reth_valid), .m_reth_addr(m_reth_addr),
    .m_reth_rkey(m_reth_rkey), .m_reth_length(m_reth_length), .m_immdt_valid(m_immdt_valid),
    .m_immdt_data(m_immdt_data), .m_payload_length(m_payload_length), .m_last(m_last),
    .next_psn(next_psn), .busy(busy), .done(done)
`ifdef ROCE_SEG_STATS_EN
    , .stat_pkts(stat_pkts), .stat_starts_dropped(stat_starts_dropped)
`endif
  );

  typedef struct {
    logic [7:0]  op;
    logic [23:0] psn;
    logic [13:0] len;
    logic        reth;
    logic        imm;
    logic        last;
  } desc_t;

  desc_t       exp_q[$];
  desc_t       got_q[$];
  int          tests = 0, fails = 0, done_cnt = 0;
  logic [23:0] model_psn = '0;
  logic [31:0] cur_len = '0, cur_rkey = '0, cur_ip = '0;
  logic [23:0] cur_qpn = '0;
  logic [63:0] cur_addr = '0;
  bit          rnd_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected packet list straight from the transfer rules: ceil division, opcode by position, PSN by count
  task automatic build(input logic [31:0] len, input logic wt);
    longint n;
    desc_t  d;
    n = (longint'(len) + PMTU - 1) / PMTU;
    if (n == 0) n = 1;
    for (longint k = 0; k < n; k++) begin
      d.psn  = model_psn + 24'(k);
      d.last = (k == n - 1);
      d.len  = d.last ? 14'(longint'(len) - (n - 1) * PMTU) : 14'(PMTU);
      if (n == 1)      d.op = wt ? 8'h0B : 8'h0A;
      else if (k == 0) d.op = 8'h06;
      else if (d.last) d.op = wt ? 8'h09 : 8'h08;
      else             d.op = 8'h07;
      d.reth = (k == 0);
      d.imm  = d.last && wt;
      exp_q.push_back(d);
    end
    model_psn = model_psn + 24'(n);
  endtask

  always @(negedge clk) begin
    desc_t e, g;
    if (done) done_cnt++;
    if (m_desc_valid) begin
      if (exp_q.size() == 0) check("unexpected_desc", 1, 0);
      else begin
        e = exp_q[0];
        check("opcode", m_opcode, e.op);
        check("psn", m_psn, e.psn);
        check("payload_len", m_payload_length, e.len);
        check("reth_valid", m_reth_valid, e.reth);
        check("immdt_valid", m_immdt_valid, e.imm);
        check("last", m_last, e.last);
        check("dest_qp", m_dest_qp, cur_qpn);
        check("ip_dest", m_ip_dest, cur_ip);
        if (e.reth) begin
          check("reth_addr", m_reth_addr, cur_addr);
          check("reth_rkey", m_reth_rkey, cur_rkey);
          check("reth_length", m_reth_length, cur_len);
        end
        if (e.imm) check("immdt_data", m_immdt_data, cur_len);
        if (m_desc_ready) begin
          g.op = m_opcode; g.psn = m_psn; g.len = m_payload_length;
          g.reth = m_reth_valid; g.imm = m_immdt_valid; g.last = m_last;
          got_q.push_back(g);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  always @(posedge clk) if (rnd_rdy) begin
    #1 m_desc_ready = 1'($urandom_range(0, 1));
  end

  task automatic run(input logic [31:0] len, input logic wt, input bit upd, input logic [23:0] lp,
                     input bit extra_start);
    got_q.delete();
    @(posedge clk); #1;
    cur_len = len; cur_rkey = 32'hA5A5_0000 ^ len; cur_ip = 32'h0A00_0001 + len;
    cur_qpn = 24'h00_1234 + len[23:0]; cur_addr = 64'h0000_7F00_0000_1000 + {32'd0, len};
    dma_length = len; write_type = wt; r_key = cur_rkey; rem_ip_addr = cur_ip;
    rem_qpn = cur_qpn; rem_addr = cur_addr; loc_psn = lp; qp_update = upd; start_transfer = 1'b1;
    if (upd) model_psn = lp;
    build(len, wt);
    done_cnt = 0;
    @(posedge clk); #1;
    start_transfer = 1'b0; qp_update = 1'b0;
    dma_length = 32'hDEAD_BEEF; rem_addr = '1; r_key = '0; rem_qpn = '0; rem_ip_addr = '0;
    check("valid_latency", m_desc_valid, 1);
    if (extra_start) begin
      @(posedge clk); #1;
      start_transfer = 1'b1; qp_update = 1'b1; loc_psn = 24'h77_7777; dma_length = 32'd100;
      @(posedge clk); #1;
      start_transfer = 1'b0; qp_update = 1'b0;
    end
    for (int c = 0; c < 3000 && done_cnt == 0; c++) @(posedge clk);
    check("done_timeout", done_cnt > 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("exp_drained", exp_q.size(), 0);
    check("busy_after", busy, 0);
    check("next_psn", next_psn, model_psn);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", m_desc_valid, 0);
    check("rst_opcode", m_opcode, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_next_psn", next_psn, 0);
    m_desc_ready = 1'b1;

    run(32'd10000, 1'b0, 1'b1, 24'h000100, 1'b0);
    check("t1_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t1_op0", got_q[0].op, 8'h06); check("t1_psn0", got_q[0].psn, 24'h100);
      check("t1_len0", got_q[0].len, 4096); check("t1_reth0", got_q[0].reth, 1);
      check("t1_op1", got_q[1].op, 8'h07); check("t1_psn1", got_q[1].psn, 24'h101);
      check("t1_op2", got_q[2].op, 8'h08); check("t1_len2", got_q[2].len, 1808);
    end
    check("t1_next_psn", next_psn, 24'h103);

    run(32'd8192, 1'b1, 1'b0, 24'h0, 1'b0);
    check("t2_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t2_op1", got_q[1].op, 8'h09); check("t2_len1", got_q[1].len, 4096);
      check("t2_imm1", got_q[1].imm, 1);
    end

    run(32'd0, 1'b0, 1'b0, 24'h0, 1'b0);
    check("t3_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      check("t3_op", got_q[0].op, 8'h0A); check("t3_len", got_q[0].len, 0);
      check("t3_last", got_q[0].last, 1);
    end

    run(32'd5000, 1'b0, 1'b1, 24'hFFFFFF, 1'b0);
    if (got_q.size() == 2) begin
      check("t4_psn0", got_q[0].psn, 24'hFFFFFF); check("t4_psn1", got_q[1].psn, 24'h000000);
    end else check("t4_count", got_q.size(), 2);
    check("t4_next_psn", next_psn, 24'h000001);

    rnd_rdy = 1'b1;
    run(32'd20000, 1'b1, 1'b0, 24'h0, 1'b1);
    rnd_rdy = 1'b0;
    @(posedge clk); #1 m_desc_ready = 1'b1;
    check("t5_count", got_q.size(), 5);
`ifdef ROCE_SEG_STATS_EN
    check("t5_starts_dropped", stat_starts_dropped, 1);
    check("t5_stat_pkts", stat_pkts, 13);
`endif

    got_q.delete();
    @(posedge clk); #1;
    cur_len = 32'd10000; dma_length = cur_len; write_type = 1'b0; qp_update = 1'b1; loc_psn = 24'h55;
    cur_rkey = 32'h1; r_key = cur_rkey; cur_ip = 32'h2; rem_ip_addr = cur_ip;
    cur_qpn = 24'h3; rem_qpn = cur_qpn; cur_addr = 64'h4; rem_addr = cur_addr;
    start_transfer = 1'b1; model_psn = 24'h55;
    build(cur_len, 1'b0);
    @(posedge clk); #1;
    start_transfer = 1'b0; qp_update = 1'b0;
    for (int c = 0; c < 100 && got_q.size() == 0; c++) @(posedge clk);
    check("t6_first_hs", got_q.size(), 1);
    #1 rst = 1'b1; m_desc_ready = 1'b0;
    @(posedge clk); #1;
    check("t6_valid_after_rst", m_desc_valid, 0);
    check("t6_busy_after_rst", busy, 0);
    check("t6_psn_after_rst", next_psn, 0);
    exp_q.delete(); model_psn = '0; rst = 1'b0; m_desc_ready = 1'b1;
    run(32'd10000, 1'b0, 1'b0, 24'h0, 1'b0);
    if (got_q.size() > 0) begin
      check("t6_fresh_op", got_q[0].op, 8'h06); check("t6_fresh_psn", got_q[0].psn, 0);
    end else check("t6_fresh_count", got_q.size(), 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/roce_write_segmenter.md
Name: roce_write_segmenter

Overview:
- Sits directly downstream of the RoCE connection manager and consumes its QP parameters and start pulse.
- Splits one RDMA WRITE transfer of dma_length bytes into PMTU-sized RC packets.
- Emits one header descriptor per packet (opcode, PSN, dest QP, RETH, immediate, payload length) over a valid/ready handshake to the RoCE header/payload builder.
- Owns the running local PSN for the QP.

Parameters:
PMTU, 4096, path MTU in bytes; power of two, 256..4096
LOG_PMTU, 12, log2(PMTU); must match PMTU

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_transfer  in  1  one-cycle request to start a transfer
dma_length  in  32  transfer length in bytes
r_key  in  32  remote key
rem_qpn  in  24  destination QP
loc_psn  in  24  PSN value loaded on qp_update
rem_ip_addr  in  32  destination IP
rem_addr  in  64  remote virtual address of the first byte
write_type  in  1  0 = plain WRITE, 1 = WRITE with immediate
qp_update  in  1  one-cycle pulse: load PSN counter from loc_psn
m_desc_valid  out  1  descriptor valid
m_desc_ready  in  1  descriptor accepted
m_opcode  out  8  BTH opcode
m_psn  out  24  BTH PSN
m_dest_qp  out  24  BTH dest QP
m_ip_dest  out  32  destination IP
m_reth_valid  out  1  RETH present
m_reth_addr  out  64  RETH virtual address
m_reth_rkey  out  32  RETH r_key
m_reth_length  out  32  RETH DMA length
m_immdt_valid  out  1  ImmDt present
m_immdt_data  out  32  immediate value, equal to dma_length
m_payload_length  out  14  payload bytes of this packet
m_last  out  1  final packet of the transfer
next_psn  out  24  PSN the next packet will use
busy  out  1  transfer in progress
done  out  1  one-cycle pulse after the last descriptor is accepted

Behaviour:
- Reset values: every output is 0; psn_reg = 0; state = IDLE.
- States: IDLE, EMIT, DONE.
- IDLE, on start_transfer=1:
  - latch all transfer inputs;
  - pkt_total = max(1, ceil(dma_length / PMTU)), computed with shifts only;
  - remaining = dma_length;
  - go to EMIT.
- m_desc_valid rises in the cycle after start is sampled (latency 1).
- EMIT:
  - The descriptor is driven from registers and held stable while valid && !ready.
  - Packet index i counts 0..pkt_total-1.
  - Opcode selection:
    - pkt_total = 1: ONLY 0x0A, or ONLY_WITH_IMM 0x0B when write_type=1.
    - i = 0: FIRST 0x06.
    - 0 < i < last: MIDDLE 0x07.
    - i = last: LAST 0x08, or LAST_WITH_IMM 0x09 when write_type=1.
  - m_reth_valid = 1 only on FIRST and ONLY. RETH carries rem_addr, r_key and dma_length.
  - m_immdt_valid = write_type on LAST and ONLY only.
  - m_payload_length = PMTU for FIRST and MIDDLE. For LAST/ONLY it is remaining, in range 0..PMTU; an exact multiple of PMTU gives PMTU.
  - dma_length = 0 produces a single ONLY packet with payload length 0.
  - m_psn = psn_reg.
  - On each handshake: psn_reg increments modulo 2^24 (0xFFFFFF wraps to 0x000000); remaining decrements by PMTU; i increments.
  - The handshake on the m_last packet moves the FSM to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- busy = 1 whenever state != IDLE.
- start_transfer while busy is ignored (no queueing).
- qp_update:
  - In IDLE: loads psn_reg <= loc_psn.
  - In the same cycle as start_transfer: the load applies first, so the transfer uses the new loc_psn.
  - While busy: ignored.
- next_psn = psn_reg at all times.
- Reset mid-transfer: valid drops in the next cycle, the partial transfer is abandoned, psn_reg returns to 0.

Optional Feature:
- Macro: ROCE_SEG_STATS_EN.
- Defined:
  - Adds outputs stat_pkts (32 bit): descriptors accepted.
  - Adds stat_starts_dropped (16 bit): start_transfer seen while busy.
  - Both are saturating and cleared on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- qp_update with loc_psn=0x000100, then start with dma_length=10000, PMTU=4096, write_type=0, ready always 1 -> 3 descriptors:
  - 0x06 / PSN 0x100 / len 4096 / RETH valid, addr = rem_addr, length 10000;
  - 0x07 / 0x101 / 4096;
  - 0x08 / 0x102 / 1808.
  - done pulses once; next_psn = 0x103.
- dma_length=8192, write_type=1 -> 0x06 (len 4096) then 0x09 (len 4096), immdt_valid=1, immdt_data=8192.
- dma_length=0 -> one 0x0A descriptor: len 0, RETH length 0, m_last=1.
- loc_psn=0xFFFFFF, dma_length=5000 -> PSNs 0xFFFFFF then 0x000000; next_psn = 0x000001.
- Backpressure: ready toggled randomly -> descriptor fields stable while stalled; no PSN skipped or duplicated. A start issued mid-transfer is ignored (stat_starts_dropped = 1 when the macro is defined).
- rst asserted after the first handshake of a 3-packet transfer -> valid = 0 the next cycle, busy = 0, next_psn = 0. A fresh start then begins at PSN 0 with opcode FIRST.
